imem_fetch_sequencer: RTL
=========================

// Module: imem_fetch_sequencer
// PURPOSE
//  Owns the program counter; sequences reads of the combinational-read instruction memory.
//  Buffers fetched words in a small FIFO, presented to decode over a valid/ready handshake.
//  Sits between the IF-stage PC logic and the IF/ID register.
//  Branch and jump redirects, fetch halt, and out-of-range or misaligned fetch faults are handled here.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset.
//  DEPTH       2              FIFO entries; legal values 2..4.
//  IMEM_WORDS  512            Words in instruction memory; fetch word index >= IMEM_WORDS faults.
// PORTS
//  Clk         in   1   Single clock; all state updates on the rising edge.
//  Rst         in   1   Synchronous, active-low reset.
//  ImemAddr    out  32  Byte address to instruction memory; equals PC, combinational from the PC register.
//  ImemInstr   in   32  Memory read data for ImemAddr, valid in the same cycle.
//  Redirect    in   1   Branch/jump taken; load RedirectPC.
//  RedirectPC  in   32  Target byte address.
//  Halt        in   1   Level signal; suspends new fetches while high.
//  InstrReady  in   1   Decode accepts the head entry this cycle.
//  InstrValid  out  1   Head entry valid.
//  Instr       out  32  Head instruction word.
//  InstrPC     out  32  Byte address of the head instruction.
//  Fault       out  1   Sticky fault flag.
// BEHAVIOUR
//  Reset (Rst==0 at edge): PC=RESET_PC, count=0, state=FETCH, Fault=0.
//   InstrValid=0, Instr=0, InstrPC=0.
//   Reset overrides every other input, including mid-redirect or in FAULT.
//  States: FETCH, HALTED, FAULT.
//  pop  = InstrValid & InstrReady.
//  push = state==FETCH & !Redirect & !Halt & (count<DEPTH | pop) & PC[31:2]<IMEM_WORDS.
//  push: write {ImemInstr, PC} at tail; PC<=PC+4 (mod 2^32).
//   Latency: the word fetched in cycle N is visible on Instr in cycle N+1.
//  Full FIFO with pop in the same cycle: push and pop both occur; count unchanged.
//  Empty FIFO: InstrValid=0; Instr/InstrPC hold their last values (don't-care to decode).
//  FIFO pointers wrap modulo DEPTH.
//  Redirect (any state except FAULT): highest priority after reset.
//   Flush all entries (count=0), no push, ignore pop; InstrValid=0 next cycle.
//   If RedirectPC[1:0]!=0: go to FAULT, Fault=1, PC unchanged.
//   Otherwise: PC<=RedirectPC; state<=FETCH, even if Halt is high.
//   With Halt still high, HALTED is re-entered in the following cycle.
//  FETCH->HALTED when Halt=1 and no Redirect; no push that cycle.
//   Existing entries still drain via pop.
//  HALTED->FETCH when Halt=0; fetch resumes at the held PC in that same cycle.
//  Range check: in FETCH with PC[31:2]>=IMEM_WORDS and no Redirect: no push; ->FAULT, Fault=1.
//   Entries already queued remain and still drain.
//  FAULT: terminal until reset. No pushes; ignores Redirect and Halt; PC frozen; pop still works.
//  ImemAddr always equals PC, including in HALTED and FAULT.
// TESTING
//  1. Reset release, InstrReady=1, memory word i = i*4:
//     InstrValid rises the cycle after reset release, with InstrPC=0, Instr=0.
//     One word per cycle follows: InstrPC 4, 8, 12...
//  2. InstrReady=0 for 5 cycles: count saturates at DEPTH and PC stops at RESET_PC+4*DEPTH.
//     Raising InstrReady drains in order with no duplicate or lost words.
//  3. Redirect=1, RedirectPC=0x40, while FIFO holds 2 entries and InstrReady=1:
//     Next cycle InstrValid=0 and PC=0x40.
//     The following cycle gives InstrPC=0x40, Instr=0x40.
//  4. Halt high 3 cycles mid-stream: PC holds; FIFO drains; InstrValid falls once empty.
//     Halt low: fetch resumes at the held PC with no skipped address.
//  5. RedirectPC=0x42 -> Fault=1 next cycle; later Redirect to 0x0 is ignored; Fault clears only on Rst=0.
//  6. RedirectPC=4*(IMEM_WORDS-1): one valid word at 0x7FC, then Fault=1.
//     A reset asserted in the same cycle as a Redirect yields PC=RESET_PC.

Source files
------------

// File: rtl/imem_fetch_sequencer.sv
// imem_fetch_sequencer
//   Owns the program counter. It sequences reads of a combinational-read
//   instruction memory and buffers fetched words in a small FIFO. That FIFO
//   feeds decode over a valid/ready handshake. Redirects, halt and fetch
//   faults (misaligned redirect target, out-of-range PC) are handled here.
//
// Ports
//   Clk, Rst      : clock; synchronous active-low reset
//   ImemAddr      : byte address to instruction memory (always the PC)
//   ImemInstr     : memory read data for ImemAddr, same cycle
//   Redirect      : load RedirectPC and flush the FIFO
//   RedirectPC    : redirect target byte address
//   Halt          : level; suspends new fetches while high
//   InstrReady    : decode accepts the head entry this cycle
//   InstrValid    : head entry valid
//   Instr/InstrPC : head instruction word and its byte address
//   Fault         : sticky fault flag, cleared only by reset
//   dbg_state     : current FSM state (FETCH=0, HALTED=1, FAULT=2)
//
// Handshake: an entry transfers on any rising edge where InstrValid and
// InstrReady are both high. InstrValid does not depend on InstrReady.
module imem_fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DEPTH      = 2,
  parameter int          IMEM_WORDS = 512
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic [31:0] ImemAddr,
  input  logic [31:0] ImemInstr,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        Halt,
  input  logic        InstrReady,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic        Fault,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } state_e;

  localparam logic [2:0]  DEPTH_C   = 3'(DEPTH);
  localparam logic [1:0]  LAST_PTR  = 2'(DEPTH - 1);
  localparam logic [29:0] WORD_LIM  = 30'(IMEM_WORDS);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  count_q, count_d;
  logic [1:0]  head_q, head_d, tail_q, tail_d;
  // Storage is sized for the largest legal DEPTH; only entries 0..DEPTH-1 are used.
  logic [31:0] instr_buf_q [4];
  logic [31:0] instr_buf_d [4];
  logic [31:0] pc_buf_q [4];
  logic [31:0] pc_buf_d [4];
  logic [31:0] instr_q, instr_d, instr_pc_q, instr_pc_d;

  logic pop, push, flush, room, in_range;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    count_d     = count_q;
    head_d      = head_q;
    tail_d      = tail_q;
    instr_buf_d = instr_buf_q;
    pc_buf_d    = pc_buf_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    push        = 1'b0;
    flush       = 1'b0;

    pop      = (count_q != 3'd0) && InstrReady;
    in_range = pc_q[31:2] < WORD_LIM;
    room     = (count_q < DEPTH_C) || pop;

    unique case (state_q)
      ST_FAULT: ;  // terminal: no fetch, Redirect/Halt ignored, pops still drain
      default: begin
        if (Redirect) begin
          flush = 1'b1;
          if (RedirectPC[1:0] != 2'b00) begin
            state_d = ST_FAULT;
          end else begin
            pc_d    = RedirectPC;
            state_d = ST_FETCH;
          end
        end else if (Halt) begin
          // Halt wins over the range check: no fetch is attempted, so no fault.
          state_d = ST_HALTED;
        end else if (!in_range) begin
          state_d = ST_FAULT;
        end else begin
          // Covers HALTED with Halt low too: fetch resumes in the same cycle.
          state_d = ST_FETCH;
          push    = room;
        end
      end
    endcase

    if (flush) begin
      count_d = 3'd0;
      head_d  = 2'd0;
      tail_d  = 2'd0;
    end else begin
      if (pop) head_d = ptr_inc(head_q);
      if (push) begin
        instr_buf_d[tail_q] = ImemInstr;
        pc_buf_d[tail_q]    = pc_q;
        tail_d              = ptr_inc(tail_q);
        pc_d                = pc_q + 32'd4;
      end
      count_d = count_q + {2'b00, push} - {2'b00, pop};
    end

    // Head outputs are registered so they hold their last value when the
    // FIFO empties. The newly pushed word becomes head only when the FIFO
    // is otherwise empty, which is exactly when tail_q lands on head_d.
    if (count_d != 3'd0) begin
      if (push && (tail_q == head_d)) begin
        instr_d    = ImemInstr;
        instr_pc_d = pc_q;
      end else begin
        instr_d    = instr_buf_q[head_d];
        instr_pc_d = pc_buf_q[head_d];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      count_q    <= 3'd0;
      head_q     <= 2'd0;
      tail_q     <= 2'd0;
      instr_q    <= 32'd0;
      instr_pc_q <= 32'd0;
      for (int i = 0; i < 4; i++) begin
        instr_buf_q[i] <= 32'd0;
        pc_buf_q[i]    <= 32'd0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      instr_buf_q <= instr_buf_d;
      pc_buf_q    <= pc_buf_d;
    end
  end

  assign ImemAddr   = pc_q;
  assign InstrValid = (count_q != 3'd0);
  assign Instr      = instr_q;
  assign InstrPC    = instr_pc_q;
  assign Fault      = (state_q == ST_FAULT);
  assign dbg_state  = state_q;

endmodule
